// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC register block: register map, bit indices,
// gain, angle limits and the arctangent table in Q3.29.
package cordic_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_THETA  = 4'h2;
  localparam logic [3:0] ADDR_COS    = 4'h3;
  localparam logic [3:0] ADDR_SIN    = 4'h4;
  localparam logic [3:0] ADDR_CFG    = 4'h5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IE     = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam int CORDIC_K = 326016437;
  localparam logic signed [31:0] PI_2     = 32'sh3243F6A9;
  localparam logic signed [31:0] NEG_PI_2 = -PI_2;

  // round(atan(2^-i) * 2^29)
  localparam logic [31:0] ATAN [30] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579, 32'd33510843,
    32'd16771758,  32'd8387925,   32'd4194219,   32'd2097141,  32'd1048575,
    32'd524288,    32'd262144,    32'd131072,    32'd65536,    32'd32768,
    32'd16384,     32'd8192,      32'd4096,      32'd2048,     32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,       32'd32,
    32'd16,        32'd8,         32'd4,         32'd2,        32'd1
  };

  typedef enum logic [1:0] {StIdle, StRun, StFinish} cordic_state_e;

  function automatic logic [31:0] apply_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic signed [31:0] clamp_theta(input logic signed [31:0] t);
    if (t > PI_2) return PI_2;
    if (t < NEG_PI_2) return NEG_PI_2;
    return t;
  endfunction

endpackage

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC rotation datapath: one micro-rotation per clock, x/y/z state,
// iteration counter and IDLE/RUN/FINISH sequencing; holds the COS/SIN results.
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int unsigned ITER  = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [31:0]      theta,
  output logic                    busy,
  output logic                    finish,
  output logic signed [WIDTH-1:0] cos_val,
  output logic signed [WIDTH-1:0] sin_val
);

  cordic_state_e           state_q;
  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_d, y_d, z_d;
  logic signed [WIDTH-1:0] x_sh, y_sh, atan_v;
  logic [4:0]              cnt_q;
  logic                    busy_q;

  always_comb begin
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_v = WIDTH'(ATAN[cnt_q]);
    // Rotate toward z == 0; z >= 0 rotates counter-clockwise.
    if (!z_q[WIDTH-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_v;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      cos_val <= '0;
      sin_val <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= WIDTH'(CORDIC_K);
            y_q     <= '0;
            z_q     <= WIDTH'(clamp_theta(theta));
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) state_q <= StFinish;
        end
        StFinish: begin
          cos_val <= x_q;
          sin_val <= y_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign finish = (state_q == StFinish);

endmodule

// File: rtl/cordic_regfile.sv
// Register front end for the CORDIC engine: byte-masked writes, W1C DONE, read mux.
// Optional interrupt output enabled by defining CORDIC_IRQ_EN.
module cordic_regfile
  import cordic_pkg::*;
#(
  parameter int unsigned ITER  = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [3:0]  reg_byte,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
`ifdef CORDIC_IRQ_EN
  output logic        irq,
`endif
  output logic        busy
);

  logic                    ie_q, done_q;
  logic [31:0]             theta_q;
  logic                    wr_ctrl, start, done_clr, finish;
  logic signed [WIDTH-1:0] cos_val, sin_val;

  assign wr_ctrl  = reg_wr && (reg_addr == ADDR_CTRL) && reg_byte[0];
  assign start    = wr_ctrl && reg_wdata[CTRL_START];
  assign done_clr = reg_wr && (reg_addr == ADDR_STATUS) && reg_byte[0] &&
                    reg_wdata[STATUS_DONE];

  cordic_iter_core #(
    .ITER  (ITER),
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .theta   (theta_q),
    .busy    (busy),
    .finish  (finish),
    .cos_val (cos_val),
    .sin_val (sin_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      theta_q <= '0;
    end else begin
      if (wr_ctrl) ie_q <= reg_wdata[CTRL_IE];
      if (reg_wr && (reg_addr == ADDR_THETA)) begin
        theta_q <= apply_bytes(theta_q, reg_wdata, reg_byte);
      end
      // A completion on the same edge as a W1C keeps DONE set.
      if (finish) done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
    end
  end

`ifdef CORDIC_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= done_q & ie_q;
  end
`endif

  always_comb begin
    reg_rdata = '0;
    if (reg_rd) begin
      case (reg_addr)
        ADDR_CTRL:   reg_rdata[CTRL_IE] = ie_q;
        ADDR_STATUS: begin
          reg_rdata[STATUS_BUSY] = busy;
          reg_rdata[STATUS_DONE] = done_q;
        end
        ADDR_THETA:  reg_rdata = theta_q;
        ADDR_COS:    reg_rdata = 32'(cos_val);
        ADDR_SIN:    reg_rdata = 32'(sin_val);
        ADDR_CFG:    reg_rdata = 32'(ITER);
        default:     reg_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_regfile.sv
// Directed self-checking bench for cordic_regfile; irq checks apply when
// CORDIC_IRQ_EN is defined.
module tb_cordic_regfile;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h1;
  localparam logic [3:0] A_THETA  = 4'h2;
  localparam logic [3:0] A_COS    = 4'h3;
  localparam logic [3:0] A_SIN    = 4'h4;
  localparam logic [3:0] A_CFG    = 4'h5;
  localparam logic [31:0] TOL     = 32'h8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [3:0]  reg_byte = '0;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        busy;
`ifdef CORDIC_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] v;

  cordic_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_byte  (reg_byte),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
`ifdef CORDIC_IRQ_EN
    .irq       (irq),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input logic [31:0] tol);
    longint diff;
    diff = longint'($signed(got)) - longint'($signed(exp));
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (tol %h)", tag, got, exp, tol);
    end
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data; reg_byte = be;
    @(posedge clk);
    #1;
    reg_wr = 1'b0; reg_byte = '0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    reg_rd = 1'b1; reg_addr = addr;
    #1;
    data = reg_rdata;
    reg_rd = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] theta,
                        input logic [31:0] exp_cos, input logic [31:0] exp_sin);
    logic [31:0] st, r;
    int waited;
    bus_write(A_THETA, theta, 4'hF);
    bus_write(A_CTRL, 32'h3, 4'h1);
    st = '0;
    waited = 0;
    while (!st[1] && waited < 40) begin
      @(posedge clk);
      waited++;
      bus_read(A_STATUS, st);
    end
    check({tag, "_done"}, st, 32'h2, 0);
    bus_read(A_COS, r);
    check({tag, "_cos"}, r, exp_cos, TOL);
    bus_read(A_SIN, r);
    check({tag, "_sin"}, r, exp_sin, TOL);
    bus_write(A_STATUS, 32'h2, 4'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_rdata", reg_rdata, 32'h0, 0);
    check("rst_busy", {31'b0, busy}, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_STATUS, v); check("rst_status", v, 32'h0, 0);
    bus_read(A_CFG, v);    check("cfg_iter", v, 32'd16, 0);
    bus_read(A_THETA, v);  check("rst_theta", v, 32'h0, 0);
    bus_read(A_COS, v);    check("rst_cos", v, 32'h0, 0);

    // Exact latency with THETA=0, a second START at edge 5, W1C at edge 17
    bus_write(A_CTRL, 32'h3, 4'h1);                 // edge 0
    check("start_busy", {31'b0, busy}, 32'h1, 0);
    repeat (4) @(posedge clk);                      // edge 4
    bus_write(A_CTRL, 32'h3, 4'h1);                 // edge 5, ignored
    repeat (11) @(posedge clk);                     // edge 16
    bus_read(A_STATUS, v); check("edge16_status", v, 32'h1, 0);
    bus_write(A_STATUS, 32'h2, 4'h1);               // edge 17, FINISH wins
    bus_read(A_STATUS, v); check("edge17_status", v, 32'h2, 0);
    check("edge17_busy", {31'b0, busy}, 32'h0, 0);
    bus_read(A_COS, v); check("zero_cos", v, 32'h20000000, TOL);
    bus_read(A_SIN, v); check("zero_sin", v, 32'h00000000, TOL);
`ifdef CORDIC_IRQ_EN
    @(posedge clk); #1;
    check("irq_set", {31'b0, irq}, 32'h1, 0);
`endif
    bus_write(A_STATUS, 32'h2, 4'h1);
    bus_read(A_STATUS, v); check("w1c_clear", v, 32'h0, 0);
`ifdef CORDIC_IRQ_EN
    @(posedge clk); #1;
    check("irq_clear", {31'b0, irq}, 32'h0, 0);
`endif
    #1;
    check("rd_low_zero", reg_rdata, 32'h0, 0);

    // Byte masking, read-only and unmapped registers
    bus_write(A_THETA, 32'h1921FB54, 4'hF);
    bus_write(A_THETA, 32'hFFFF1234, 4'b0011);
    bus_read(A_THETA, v); check("theta_bytes", v, 32'h19211234, 0);
    bus_write(A_COS, 32'hDEADBEEF, 4'hF);
    bus_read(A_COS, v); check("cos_ro", v, 32'h20000000, TOL);
    bus_write(A_CFG, 32'h0, 4'hF);
    bus_read(A_CFG, v); check("cfg_ro", v, 32'd16, 0);
    bus_write(4'h9, 32'hFFFFFFFF, 4'hF);
    bus_read(4'h9, v); check("unmapped", v, 32'h0, 0);
    bus_read(A_CTRL, v); check("ctrl_ie", v, 32'h2, 0);

    // Angle vectors
    run_op("pi4",     32'h1921FB54, 32'h16A09E66, 32'h16A09E66);
    run_op("negpi2",  32'hCDBC0957, 32'h00000000, 32'hE0000000);
    run_op("clamp_hi", 32'h40000000, 32'h00000000, 32'h20000000);
    run_op("pi2",     32'h3243F6A9, 32'h00000000, 32'h20000000);
    run_op("clamp_lo", 32'h80000000, 32'h00000000, 32'hE0000000);

    // Reset in the middle of a run
    bus_write(A_THETA, 32'h1921FB54, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'h1);                 // edge 0
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0, 0);
    bus_read(A_STATUS, v); check("abort_status", v, 32'h0, 0);
    bus_read(A_COS, v);    check("abort_cos", v, 32'h0, 0);
    bus_read(A_SIN, v);    check("abort_sin", v, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_THETA, v);  check("abort_theta", v, 32'h0, 0);
    run_op("post_rst", 32'h1921FB54, 32'h16A09E66, 32'h16A09E66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
